// File: rtl/sobel_pkg.sv
// sobel_pkg: shared constants, pixel layout and feeder state type for the Sobel front end
package sobel_pkg;
  localparam int PIXELS_PER_LINE = 16;
  localparam int KERNEL_SIZE = 512;
  localparam int COEF_R = 77;
  localparam int COEF_G = 150;
  localparam int COEF_B = 29;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} feeder_state_t;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_bgra_t;
endpackage

// File: rtl/sobel_gray_lane.sv
// sobel_gray_lane: one-pixel BGRA to 8-bit luminance, products then rounded sum
module sobel_gray_lane
  import sobel_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        en1,
  input  logic        en2,
  input  logic [31:0] pixel,
  output logic [7:0]  y
);
  pixel_bgra_t p;
  logic [15:0] pr, pg, pb, sum;
  logic unused_a;
  assign p = pixel_bgra_t'(pixel);
  assign unused_a = ^p.a;
  assign sum = pr + pg + pb + 16'd128;
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      pr <= '0;
      pg <= '0;
      pb <= '0;
      y  <= '0;
    end else begin
      if (en1) begin
        pr <= {8'd0, p.r} * 16'(COEF_R);
        pg <= {8'd0, p.g} * 16'(COEF_G);
        pb <= {8'd0, p.b} * 16'(COEF_B);
      end
      if (en2) y <= sum[15:8];
    end
  end
endmodule

// File: rtl/sobel_gray_feeder.sv
// sobel_gray_feeder: converts BGRA cache lines to gray lines and appends zero flush beats per frame
module sobel_gray_feeder
  import sobel_pkg::*;
#(
  parameter int PIXELS      = PIXELS_PER_LINE,
  parameter int FLUSH_BEATS = KERNEL_SIZE / PIXELS_PER_LINE,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_lines,
  input  logic                  valid_in,
  input  logic [32*PIXELS-1:0]  data_in,
  output logic                  valid_out,
  output logic [8*PIXELS-1:0]   data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);
  localparam int FW = $clog2(FLUSH_BEATS + 1);
  feeder_state_t state, state_d;
  logic [CNT_W-1:0] lines, line_cnt;
  logic [FW-1:0] flush_cnt;
  logic v1, v2, take, fin, zero_start, go;
  assign go = (state == IDLE) && start;
  always_comb begin
    state_d = state;
    take = 1'b0;
    fin = 1'b0;
    zero_start = 1'b0;
    case (state)
      IDLE: begin
        zero_start = start && (num_lines == '0);
        state_d = (start && num_lines != '0) ? RUN : IDLE;
      end
      RUN: begin
        take = valid_in;
        state_d = (valid_in && line_cnt + CNT_W'(1) == lines) ? FLUSH : RUN;
      end
      FLUSH: begin
        take = 1'b1;
        state_d = (flush_cnt == FW'(FLUSH_BEATS - 1)) ? DRAIN : FLUSH;
      end
      DRAIN: begin
        // stage 1 empty means the last flush beat is on the output this cycle
        fin = !v1;
        state_d = v1 ? DRAIN : IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= IDLE;
      lines     <= '0;
      line_cnt  <= '0;
      flush_cnt <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_d;
      v1        <= take;
      v2        <= v1;
      done      <= fin | zero_start;
      overrun   <= go ? 1'b0 : overrun | (valid_in && state != RUN);
      flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
      if (go) begin
        lines    <= num_lines;
        line_cnt <= '0;
      end else if (take && state == RUN) begin
        line_cnt <= line_cnt + CNT_W'(1);
      end
    end
  end
  assign valid_out = v2;
  assign busy = (state != IDLE) | v1 | v2;
  for (genvar i = 0; i < PIXELS; i++) begin : g_lane
    logic [31:0] px;
    assign px = (state == FLUSH) ? 32'd0 : data_in[32*i +: 32];
    sobel_gray_lane u_lane (
      .clk   (clk),
      .rst_b (rst_b),
      .en1   (take),
      .en2   (v1),
      .pixel (px),
      .y     (data_out[8*i +: 8])
    );
  end
endmodule
